// File: rtl/serial_pkg.sv
// Shared encodings for the serial frame transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high and flags
// the last cycle of each serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Held at zero while idle so every frame starts on a fresh bit period.
  always_comb begin
    cnt_next = cnt_reg;
    if (!run || (cnt_reg == CNT_LAST)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_end = run && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB
// first, stop bit, each held for CLKS_PER_BIT cycles. All outputs but
// in_ready are registered.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                tx_reg, tx_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                bit_end;
  logic                handshake;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_reg != IDLE),
    .bit_end (bit_end)
  );

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign handshake = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          shift_next = in_data;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx changes on the same
  // edge as the state, keeping the output fully registered.
  always_comb begin
    tx_next = LINE_IDLE;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = LINE_IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= LINE_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter: accepts one DATA_W-bit word over a valid/ready handshake and drives it onto a single-bit line as start bit, data (LSB first) and stop bit. Each bit is held for CLKS_PER_BIT clock cycles. This is the driving end of the single-bit links that the capture flip-flops in this codebase sample. It sits between a word-level producer and the serial line register.

## Interface
- DATA_W, 8: data word width, ≥1.
- CLKS_PER_BIT, 4: clock cycles per serial bit, ≥1.
- clk  in  1  single system clock; all state updates on posedge clk.
- rst  in  1  reset, asynchronous and active-high.
- in_data  in  DATA_W  word to send; sampled only on handshake.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- tx  out  1  serial line; idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: tx=1, in_ready=0 while rst is high (1 from first cycle after release), busy=0, done=0, state IDLE, shift register 0, counters 0.
- States:
  - IDLE: tx=1, in_ready=1. On in_valid & in_ready, latch in_data and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index. After bit DATA_W-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for that first IDLE cycle.
- tx, busy and done are registered outputs; there is no combinational path from inputs to outputs. in_ready is decoded from state (IDLE and not in reset).
- Cycle counter: width $clog2(CLKS_PER_BIT) (minimum 1). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index: width $clog2(DATA_W) (minimum 1). It advances only at DATA bit boundaries.
- in_data changes while busy are ignored. The latched copy is the one transmitted.
- in_valid while not in IDLE is held off by in_ready=0. The word is not lost; the producer keeps in_valid asserted.
- Back-to-back frames: a valid word present in the done cycle is accepted in that same cycle. Minimum gap between stop bit and next start bit is exactly one idle cycle.
- rst asserted mid-frame: tx goes to 1 immediately (asynchronous), the frame is dropped, no done pulse is generated, and the block returns to IDLE.
- CLKS_PER_BIT=1: each bit lasts one cycle; the counter is effectively constant 0.

## Timing
- Handshake at edge N: tx=0 (start bit) from cycle N+1.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles on tx.
- done pulses in cycle N+1+(DATA_W+2)*CLKS_PER_BIT; in_ready=1 in that same cycle.
- busy=1 from cycle N+1 through the last stop-bit cycle.
- Throughput: one word per (DATA_W+2)*CLKS_PER_BIT+1 cycles.

## Structure
- Shared package serial_pkg holds the state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the idle line level constant LINE_IDLE=1'b1. The matching receiver reuses this package.
- One sub-module, bit_timer: parameter CLKS_PER_BIT, inputs clk/rst/run, output bit_end (high in the last cycle of each bit). The FSM, shift register and bit index stay in serial_frame_tx.

## Test plan
- Reset: assert rst for 3 cycles mid-simulation. Require tx=1, busy=0, done=0 during reset, and in_ready=1 one cycle after release.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, in_data=8'hA5. Require tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total), and done on cycle 41 after the handshake.
- Back-to-back: hold in_valid high with 8'h00 then 8'hFF. Require the second start bit exactly 1 cycle after the first stop bit ends, and exactly two done pulses.
- Ignored input: change in_data to 8'h3C mid-frame of 8'hA5. Require the transmitted bits to remain those of 8'hA5, and in_ready=0 throughout the frame.
- Reset mid-frame: assert rst during data bit 3. Require tx=1 in the same cycle, no done pulse, and a new word after release to produce a clean full frame.
- Edge parameters, CLKS_PER_BIT=1 and DATA_W=1, in_data=1'b1. Require tx sequence 0,1,1 over 3 cycles, with done on the 4th cycle.
